// File: rtl/muldiv_pkg.sv
// Shared encodings and defaults for the muldiv_seq iterative multiply/divide unit.
package muldiv_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    FIX
  } state_e;

  function automatic logic is_signed_op(input op_e op);
    return ~op[0];
  endfunction

  function automatic logic is_div_op(input op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: add-shift for multiply, or restoring trial-subtract-shift
// for divide when MULDIV_SEQ_DIV_EN is defined.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
`ifdef MULDIV_SEQ_DIV_EN
  input  logic               div_i,
`endif
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0] sum;

  // NOTE: every always_comb output gets a full assignment on every path, so no latch is inferred.
  always_comb begin
    sum = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
  end

`ifdef MULDIV_SEQ_DIV_EN
  // Partial remainder is the old remainder with the next dividend bit shifted in.
  logic [WIDTH+1:0] diff;

  always_comb begin
    diff = {1'b0, acc_i[2*WIDTH-1:WIDTH-1]} - {2'b00, opnd_i};
    if (!div_i)
      acc_o = {sum, acc_i[WIDTH-1:1]};
    else if (diff[WIDTH+1])
      acc_o = {acc_i[2*WIDTH-2:0], 1'b0};
    else
      acc_o = {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
  end
`else
  always_comb begin
    acc_o = {sum, acc_i[WIDTH-1:1]};
  end
`endif

endmodule

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer writing HI/LO; the divide path is
// built only when MULDIV_SEQ_DIV_EN is defined.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] src_a_i,
  input  logic [WIDTH-1:0] src_b_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_zero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [WIDTH-1:0]   opnd_q;
  logic               neg_q;
  logic               is_div_q;
  logic               done_q;
  logic               div_zero_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic               sign_a;
  logic               sign_b;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    sign_a = is_signed_op(op_e'(op_i)) & src_a_i[WIDTH-1];
    sign_b = is_signed_op(op_e'(op_i)) & src_b_i[WIDTH-1];
    mag_a  = sign_a ? -src_a_i : src_a_i;
    mag_b  = sign_b ? -src_b_i : src_b_i;
    prod   = neg_q ? -acc_q : acc_q;
  end

`ifdef MULDIV_SEQ_DIV_EN
  logic             sign_a_q;
  logic             dz_q;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;

  // Remainder takes the dividend's sign; quotient takes the xor of both signs.
  always_comb begin
    quo = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .div_i  (state_q == DIV),
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .acc_o  (acc_d)
  );
`else
  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .acc_o  (acc_d)
  );
`endif

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      neg_q      <= 1'b0;
      is_div_q   <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
`ifdef MULDIV_SEQ_DIV_EN
      sign_a_q   <= 1'b0;
      dz_q       <= 1'b0;
`endif
    end else begin
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_i && !flush_i) begin
            cnt_q    <= '0;
            neg_q    <= sign_a ^ sign_b;
            is_div_q <= is_div_op(op_e'(op_i));
`ifdef MULDIV_SEQ_DIV_EN
            sign_a_q <= sign_a;
            dz_q     <= 1'b0;
`endif
            if (!is_div_op(op_e'(op_i))) begin
              acc_q   <= {{WIDTH{1'b0}}, mag_b};
              opnd_q  <= mag_a;
              state_q <= MUL;
            end
`ifdef MULDIV_SEQ_DIV_EN
            else if (src_b_i == '0) begin
              // Preload the divide-by-zero result so FIX only has to copy it out.
              acc_q   <= {src_a_i, {WIDTH{1'b1}}};
              dz_q    <= 1'b1;
              state_q <= FIX;
            end else begin
              acc_q   <= {{WIDTH{1'b0}}, mag_a};
              opnd_q  <= mag_b;
              state_q <= DIV;
            end
`else
            else begin
              state_q <= FIX;
            end
`endif
          end
        end
        MUL, DIV: begin
          if (flush_i) begin
            state_q <= IDLE;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST) state_q <= FIX;
          end
        end
        FIX: begin
          state_q <= IDLE;
          if (!flush_i) begin
            done_q <= 1'b1;
`ifdef MULDIV_SEQ_DIV_EN
            if (dz_q) begin
              hi_q       <= acc_q[2*WIDTH-1:WIDTH];
              lo_q       <= acc_q[WIDTH-1:0];
              div_zero_q <= 1'b1;
            end else if (is_div_q) begin
              hi_q <= rem;
              lo_q <= quo;
            end else begin
              hi_q <= prod[2*WIDTH-1:WIDTH];
              lo_q <= prod[WIDTH-1:0];
            end
`else
            if (!is_div_q) begin
              hi_q <= prod[2*WIDTH-1:WIDTH];
              lo_q <= prod[WIDTH-1:0];
            end
`endif
          end
        end
      endcase
    end
  end

  assign busy_o     = (state_q != IDLE);
  assign done_o     = done_q;
  assign div_zero_o = div_zero_q;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq; divide expectations follow MULDIV_SEQ_DIV_EN.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  localparam int W = 32;

`ifdef MULDIV_SEQ_DIV_EN
  localparam logic [1:0] RST_OP = OP_DIVU;
`else
  localparam logic [1:0] RST_OP = OP_MULTU;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         flush;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         dz;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  always #5 clk = ~clk;

  muldiv_seq #(.WIDTH(W)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .op_i       (op),
    .src_a_i    (a),
    .src_b_i    (b),
    .flush_i    (flush),
    .busy_o     (busy),
    .done_o     (done),
    .div_zero_o (dz),
    .hi_o       (hi),
    .lo_o       (lo)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Issues one request, follows it to Done and checks latency, Busy span, result and HI/LO stability.
  // A nonzero inject cycle presents a bogus divide-by-zero Start while the op is in flight.
  task automatic op_check(input string tag, input logic [1:0] o, input logic [W-1:0] sa,
                          input logic [W-1:0] sb, input int exp_edges, input logic [W-1:0] ehi,
                          input logic [W-1:0] elo, input logic edz, input int inject);
    int   n = -1;
    int   busy_cycles = 0;
    int   unstable = 0;
    logic busy_at_done = 1'b1;
    start = 1'b1; op = o; a = sa; b = sb;
    #1 check({tag, " busy_pre"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, " busy_edge0"}, 32'(busy), 32'd1);
    check({tag, " done_low"}, 32'(done), 32'd0);
    if (busy) busy_cycles++;
    for (int i = 1; i <= 100 && n < 0; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin
        n = i;
        busy_at_done = busy;
      end else begin
        if (busy) busy_cycles++;
        if (hi !== m_hi || lo !== m_lo) unstable++;
        if (i == inject) begin
          start = 1'b1; op = OP_DIVU; a = '0; b = '0;
        end
      end
    end
    check({tag, " edges"}, 32'(n), 32'(exp_edges));
    check({tag, " busy_span"}, 32'(busy_cycles), 32'(exp_edges));
    check({tag, " busy_done"}, 32'(busy_at_done), 32'd0);
    check({tag, " hi"}, hi, ehi);
    check({tag, " lo"}, lo, elo);
    check({tag, " divzero"}, 32'(dz), 32'(edz));
    check({tag, " hold"}, 32'(unstable), 32'd0);
    m_hi = ehi;
    m_lo = elo;
  endtask

  task automatic div_op(input string tag, input logic [1:0] o, input logic [W-1:0] sa,
                        input logic [W-1:0] sb, input logic [W-1:0] q, input logic [W-1:0] r,
                        input logic zero);
`ifdef MULDIV_SEQ_DIV_EN
    op_check(tag, o, sa, sb, zero ? 1 : W + 1, r, q, zero, 0);
`else
    op_check(tag, o, sa, sb, 1, m_hi, m_lo, 1'b0, 0);
`endif
  endtask

  task automatic count_done(input int cycles, output int cnt);
    cnt = 0;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (done) cnt++;
    end
  endtask

  initial begin
    int dcnt;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    #12;
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst divzero", 32'(dz), 32'd0);
    check("rst hi", hi, 32'd0);
    check("rst lo", lo, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    op_check("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33,
             32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 5);
    op_check("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd5, 33,
             32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 0);
    op_check("mult_minmin", OP_MULT, 32'h8000_0000, 32'h8000_0000, 33,
             32'h4000_0000, 32'h0000_0000, 1'b0, 0);
    div_op("div_neg7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    div_op("div_7_neg2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0);
    div_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
    div_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    div_op("divu_zero", OP_DIVU, 32'd100, 32'd0, 32'hFFFF_FFFF, 32'h0000_0064, 1'b1);
    op_check("multu_after", OP_MULTU, 32'd6, 32'd7, 33, 32'd0, 32'd42, 1'b0, 0);

    // Flush ten cycles into a MULT.
    start = 1'b1; op = OP_MULT; a = 32'd7; b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("flush busy_before", 32'(busy), 32'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush busy_after", 32'(busy), 32'd0);
    count_done(40, dcnt);
    check("flush no_done", 32'(dcnt), 32'd0);
    check("flush hi", hi, m_hi);
    check("flush lo", lo, m_lo);

    // Flush and Start together in IDLE: request dropped.
    start = 1'b1; flush = 1'b1; op = OP_MULTU; a = 32'd2; b = 32'd2;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("flush_start busy", 32'(busy), 32'd0);
    count_done(40, dcnt);
    check("flush_start no_done", 32'(dcnt), 32'd0);

    // Asynchronous reset between edges 5 and 6 of an operation.
    start = 1'b1; op = RST_OP; a = 32'd1000; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("midrst busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst done", 32'(done), 32'd0);
    check("midrst divzero", 32'(dz), 32'd0);
    check("midrst hi", hi, 32'd0);
    check("midrst lo", lo, 32'd0);
    #1 rst = 1'b0;
    m_hi = '0;
    m_lo = '0;
    count_done(40, dcnt);
    check("midrst no_done", 32'(dcnt), 32'd0);
    op_check("multu_3x4", OP_MULTU, 32'd3, 32'd4, 33, 32'd0, 32'd12, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
